// File: rtl/fetch_sequencer_if.sv
// Instruction-memory request/response bus between the fetch sequencer and imem.
interface fetch_sequencer_if #(
  parameter int WORD    = 64,
  parameter int INSTR_W = 32
);
  logic               imem_req;
  logic [WORD-1:0]    imem_addr;
  logic               imem_ready;
  logic [INSTR_W-1:0] imem_data;

  modport master (output imem_req, imem_addr, input imem_ready, imem_data);
  modport slave  (input imem_req, imem_addr, output imem_ready, imem_data);
endinterface

// File: rtl/fetch_sequencer.sv
// Fetch-stage PC sequencer: one outstanding imem request, holds the returned
// instruction for decode, redirects on taken branches, sticky fault on timeout/misalignment.
module fetch_sequencer #(
  parameter int              WORD     = 64,
  parameter int              INSTR_W  = 32,
  parameter logic [WORD-1:0] RESET_PC = '0,
  parameter int              PC_INC   = 4,
  parameter int              MAX_WAIT = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                stall,
  input  logic                dec_ready,
  input  logic                br_taken,
  input  logic [WORD-1:0]     br_target,
  fetch_sequencer_if.master   imem,
  output logic [INSTR_W-1:0]  instr,
  output logic [WORD-1:0]     instr_pc,
  output logic                instr_valid,
  output logic [WORD-1:0]     pc,
  output logic                fetch_fault
);

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_HOLD, S_FAULT} state_t;

  localparam int               CNT_W    = $clog2(MAX_WAIT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_WAIT - 1);
  localparam logic [WORD-1:0]  PC_STEP  = WORD'(PC_INC);

  state_t           state;
  logic [CNT_W-1:0] wait_cnt;
  logic             flush;
  logic             req_q;
  logic             br_bad;
  logic             br_ok;

  assign br_bad         = br_taken && (br_target[1:0] != 2'b00);
  assign br_ok          = br_taken && !br_bad;
  assign imem.imem_addr = pc;
  assign imem.imem_req  = req_q;

  // imem_req is registered, so it is raised on every transition into S_REQ.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      pc          <= RESET_PC;
      wait_cnt    <= '0;
      flush       <= 1'b0;
      req_q       <= 1'b0;
      instr       <= '0;
      instr_pc    <= '0;
      instr_valid <= 1'b0;
      fetch_fault <= 1'b0;
    end else begin
      req_q <= 1'b0;
      if (state != S_FAULT && br_bad) begin
        state       <= S_FAULT;
        fetch_fault <= 1'b1;
        instr_valid <= 1'b0;
        flush       <= 1'b0;
      end else begin
        if (state != S_FAULT && br_ok) begin
          pc <= br_target;
        end
        unique case (state)
          S_IDLE: begin
            if (!stall) begin
              state <= S_REQ;
              req_q <= 1'b1;
            end
          end
          S_REQ: begin
            state    <= S_WAIT;
            wait_cnt <= '0;
            if (br_ok) begin
              flush <= 1'b1;
            end
          end
          S_WAIT: begin
            if (imem.imem_ready) begin
              // A redirect seen before or with the response makes the data stale.
              if (flush || br_ok) begin
                flush <= 1'b0;
                state <= S_REQ;
                req_q <= 1'b1;
              end else begin
                instr       <= imem.imem_data;
                instr_pc    <= pc;
                instr_valid <= 1'b1;
                pc          <= pc + PC_STEP;
                state       <= S_HOLD;
              end
            end else begin
              if (br_ok) begin
                flush <= 1'b1;
              end
              if (wait_cnt == CNT_LAST) begin
                state       <= S_FAULT;
                fetch_fault <= 1'b1;
              end else begin
                wait_cnt <= wait_cnt + 1'b1;
              end
            end
          end
          S_HOLD: begin
            if (br_ok || (dec_ready && !stall)) begin
              instr_valid <= 1'b0;
              state       <= S_REQ;
              req_q       <= 1'b1;
            end
          end
          S_FAULT: begin
          end
          default: begin
            state <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Controls the fetch-stage program counter register and the instruction-memory request handshake.
- Issues one fetch at a time, holds each returned instruction until the decode stage accepts it, and advances the PC by PC_INC.
- Redirects the PC on a taken branch and discards any in-flight response.
- Raises a sticky fault on a memory timeout or a misaligned branch target.

Parameters:
WORD, 64, PC and address width in bits
INSTR_W, 32, instruction width in bits
RESET_PC, 0, PC value loaded on reset
PC_INC, 4, PC increment per fetched instruction
MAX_WAIT, 16, cycles allowed in S_WAIT before fault

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-high reset
stall  input  1  blocks issue of a new fetch
dec_ready  input  1  decode stage accepts instr this cycle
br_taken  input  1  taken-branch redirect strobe, single cycle
br_target  input  WORD  redirect address, sampled when br_taken=1
imem_req  output  1  fetch request strobe, one cycle wide
imem_addr  output  WORD  fetch address, equals pc
imem_ready  input  1  memory response valid
imem_data  input  INSTR_W  memory response data
instr  output  INSTR_W  held instruction
instr_pc  output  WORD  address of held instruction
instr_valid  output  1  instr/instr_pc valid
pc  output  WORD  current PC register
fetch_fault  output  1  sticky fault flag

Behaviour:
- One clock domain. Reset is synchronous and active-high.
- Reset values: pc=RESET_PC, state=S_IDLE, wait counter=0, flush flag=0, imem_req=0, instr=0, instr_pc=0, instr_valid=0, fetch_fault=0.
- Reset takes effect at any point, including mid-transaction. Any imem_ready after reset is ignored because the state is S_IDLE.
- imem_addr is driven directly from the pc register (combinational). All other outputs are registered.
- State S_IDLE: go to S_REQ when stall=0, otherwise stay.
- State S_REQ: imem_req=1 for exactly this cycle. Next state S_WAIT, counter cleared. Memory responds no earlier than the cycle after imem_req.
- State S_WAIT, imem_ready=1 with flush=0: latch instr=imem_data and instr_pc=pc, set instr_valid, update pc to pc+PC_INC, go to S_HOLD.
- State S_WAIT, imem_ready=1 with flush=1: discard the data, clear flush, go to S_REQ.
- State S_WAIT, imem_ready=0: increment the counter. When the counter reaches MAX_WAIT-1, go to S_FAULT.
- State S_HOLD: instr_valid=1 and instr/instr_pc are stable. When dec_ready=1 and stall=0, instr_valid clears next cycle and the state goes to S_REQ.
- State S_HOLD with stall=1: stays in S_HOLD, regardless of dec_ready.
- Throughput: one instruction per 3 cycles with zero-wait memory (REQ, WAIT, HOLD).
- PC arithmetic: pc+PC_INC is modulo 2^WORD, so 0xFFFFFFFFFFFFFFFC wraps to 0.
- br_taken has priority over increment. In any state except S_FAULT: pc <= br_target next cycle.
- br_taken in S_REQ: the issued request becomes stale. Set flush and go to S_WAIT.
- br_taken in S_WAIT with imem_ready=0: set flush. Stay in S_WAIT; the counter keeps running.
- br_taken in S_WAIT with imem_ready=1 in the same cycle: discard the response, go to S_REQ. instr_valid stays 0.
- br_taken in S_HOLD: instr_valid clears next cycle (the held instruction is dropped even if dec_ready=1), go to S_REQ, ignoring stall.
- br_taken in S_IDLE: load pc. Normal stall rule then applies.
- Misaligned target: br_taken=1 with br_target[1:0]!=0 goes to S_FAULT, and pc is not updated.
- State S_FAULT: fetch_fault=1, imem_req=0, instr_valid=0, pc frozen. All inputs ignored. Exit only by reset.
- imem_ready in S_IDLE, S_REQ, S_HOLD or S_FAULT is ignored.

Test Plan:
- Basic fetch, 1-cycle memory: release reset, stall=0, dec_ready=1, imem_ready=1 the cycle after each imem_req, data 0xAAAA0000+n -> imem_addr sequence 0,4,8; instr_valid pulses every 3 cycles with instr_pc 0,4,8; pc ends at 12.
- Stall and backpressure: hold dec_ready=0 for 5 cycles, then stall=1 for 3 cycles with dec_ready=1 -> instr stays 0xAAAA0000 and instr_valid stays 1 for all 8 cycles; no imem_req until stall drops.
- Branch flush: pc=0x100, br_taken=1 with br_target=0x2000 during S_WAIT, memory returns 0xDEAD 3 cycles later -> 0xDEAD never appears on instr; next imem_req has imem_addr=0x2000; returned instr_pc=0x2000.
- Timeout and misalignment: never assert imem_ready -> fetch_fault=1 exactly MAX_WAIT cycles after S_WAIT entry. Separately, br_target=0x1002 -> fetch_fault=1 next cycle with pc unchanged. Both remain sticky until reset.
- Wrap and reset: branch to 0xFFFFFFFFFFFFFFFC, complete one fetch -> pc=0. Assert reset during S_WAIT with imem_ready=1 the following cycle -> pc=RESET_PC, instr_valid=0, response ignored.
